// File: rtl/ct_f_spsram_pkg.sv
// rtl/ct_f_spsram_pkg.sv - shared types and parameter helpers for ct_f_spsram_gen
package ct_f_spsram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int seg_num(input int data_width, input int mask_gran);
    return data_width / mask_gran;
  endfunction

  function automatic bit params_legal(input int addr_width, input int depth,
                                      input int data_width, input int mask_gran);
    longint max_depth;
    max_depth = longint'(1) << addr_width;
    return (depth > 0) && (longint'(depth) <= max_depth) &&
           (mask_gran > 0) && (data_width > 0) &&
           ((data_width % mask_gran) == 0);
  endfunction

endpackage

// File: rtl/ct_f_spsram_seg.sv
// rtl/ct_f_spsram_seg.sv - one behavioural BRAM column, MASK_GRAN wide, single write enable
module ct_f_spsram_seg #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 1,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Asynchronous read; the top level owns the output register and range masking.
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ct_f_spsram_gen.sv
// rtl/ct_f_spsram_gen.sv - parametrised single-port SRAM; CT_F_SPSRAM_INIT_EN adds a post-reset clearing sweep
module ct_f_spsram_gen
  import ct_f_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096,
  parameter int DATA_WIDTH = 144,
  parameter int MASK_GRAN  = 1,
  parameter int SEG_NUM    = seg_num(DATA_WIDTH, MASK_GRAN)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [SEG_NUM-1:0]    WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  BUSY,
  output logic                  OOR
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (!params_legal(ADDR_WIDTH, DEPTH, DATA_WIDTH, MASK_GRAN)) begin : g_bad_params
    $error("ct_f_spsram_gen: illegal DEPTH/MASK_GRAN/DATA_WIDTH combination");
  end

  logic                  busy;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef CT_F_SPSRAM_INIT_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= INIT;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      INIT: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = READY;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy     = (state_q == INIT);
  assign clr_addr = clr_addr_q;
`else
  assign busy     = 1'b0;
  assign clr_addr = '0;
`endif

  logic                  acc, in_range, wr, rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic [SEG_NUM-1:0]    seg_we;

  assign acc      = !CEN && !busy;
  assign in_range = (32'(A) < 32'(DEPTH));
  assign wr       = acc && !GWEN && in_range;
  assign rd       = acc && GWEN;

  // During the sweep the counter owns the array and every column writes zero.
  assign mem_addr  = busy ? clr_addr : A;
  assign mem_wdata = busy ? '0 : D;

  for (genvar s = 0; s < SEG_NUM; s++) begin : g_seg
    assign seg_we[s] = busy || (wr && !WEN[s]);

    ct_f_spsram_seg #(
      .DEPTH (DEPTH),
      .WIDTH (MASK_GRAN),
      .IDX_W (IDX_W)
    ) u_seg (
      .clk_i   (CLK),
      .we_i    (seg_we[s]),
      .addr_i  (mem_addr[IDX_W-1:0]),
      .wdata_i (mem_wdata[s*MASK_GRAN +: MASK_GRAN]),
      .rdata_o (mem_rdata[s*MASK_GRAN +: MASK_GRAN])
    );
  end

  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  oor_q, oor_d;

  always_comb begin
    q_d   = q_q;
    oor_d = acc && !in_range;
    if (rd) begin
      q_d = in_range ? mem_rdata : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q   <= '0;
      oor_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      oor_q <= oor_d;
    end
  end

  assign Q    = q_q;
  assign OOR  = oor_q;
  assign BUSY = busy;

endmodule

// File: tb/tb_ct_f_spsram_gen.sv
// tb/tb_ct_f_spsram_gen.sv - directed self-checking bench for ct_f_spsram_gen (sweep tests under CT_F_SPSRAM_INIT_EN)
module tb_ct_f_spsram_gen;

  localparam int AW    = 12;
  localparam int DEPTH = 3000;
  localparam int DW    = 144;
  localparam int MG    = 8;
  localparam int SEGS  = DW / MG;

  logic            CLK = 1'b0;
  logic            RST;
  logic [AW-1:0]   A;
  logic            CEN;
  logic            GWEN;
  logic [SEGS-1:0] WEN;
  logic [DW-1:0]   D;
  logic [DW-1:0]   Q;
  logic            BUSY;
  logic            OOR;

  int checks   = 0;
  int failures = 0;

  localparam logic [DW-1:0]   PAT_5A   = {18{8'h5A}};
  localparam logic [DW-1:0]   PAT_A1   = {18{8'hA1}};
  localparam logic [DW-1:0]   PAT_B2   = {18{8'hB2}};
  localparam logic [DW-1:0]   PAT_C3   = {18{8'hC3}};
  localparam logic [DW-1:0]   ONES     = {DW{1'b1}};
  localparam logic [SEGS-1:0] WEN_ALL  = '0;
  localparam logic [SEGS-1:0] WEN_NONE = '1;

  ct_f_spsram_gen #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .MASK_GRAN  (MG)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .A    (A),
    .CEN  (CEN),
    .GWEN (GWEN),
    .WEN  (WEN),
    .D    (D),
    .Q    (Q),
    .BUSY (BUSY),
    .OOR  (OOR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic cen, input logic gwen, input logic [SEGS-1:0] wen,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    CEN  = cen;
    GWEN = gwen;
    WEN  = wen;
    A    = a;
    D    = d;
    tick();
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, WEN_NONE, '0, '0);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    CEN = 1'b1; GWEN = 1'b1; WEN = WEN_NONE; A = '0; D = '0;
    tick();
    tick();
    checks++;
    if (Q !== '0) begin failures++; $display("FAIL reset_q got=%h exp=0", Q); end
    checks++;
    if (OOR !== 1'b0) begin failures++; $display("FAIL reset_oor got=%b exp=0", OOR); end
`ifdef CT_F_SPSRAM_INIT_EN
    checks++;
    if (BUSY !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", BUSY); end
`else
    checks++;
    if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    RST = 1'b0;
`endif
  endtask

`ifdef CT_F_SPSRAM_INIT_EN
  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < DEPTH + 10) begin
      tick();
      n++;
    end
    checks++;
    if (n != DEPTH) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, n, DEPTH); end
  endtask

  task automatic test_init_sweep();
    CEN = 1'b0; GWEN = 1'b1; WEN = WEN_NONE; A = 12'd5; D = ONES;
    RST = 1'b0;
    count_busy("sweep");
    checks++;
    if (Q !== '0) begin failures++; $display("FAIL sweep_reads_ignored got=%h exp=0", Q); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, WEN_NONE, AW'(i), '0);
      checks++;
      if (Q !== '0) begin failures++; $display("FAIL sweep_zero addr=%0d got=%h exp=0", i, Q); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    drive(1'b0, 1'b0, WEN_ALL, 12'd3, PAT_C3);
    RST = 1'b1;
    idle();
    RST = 1'b0;
    for (int i = 0; i < 7; i++) idle();
    RST = 1'b1;
    idle();
    checks++;
    if (BUSY !== 1'b1) begin failures++; $display("FAIL mid_reset_busy got=%b exp=1", BUSY); end
    RST = 1'b0;
    CEN = 1'b0; GWEN = 1'b1; A = 12'd3;
    count_busy("mid_sweep");
    drive(1'b0, 1'b1, WEN_NONE, 12'd3, '0);
    checks++;
    if (Q !== '0) begin failures++; $display("FAIL mid_sweep_cleared got=%h exp=0", Q); end
  endtask
`endif

  task automatic test_write_read();
    drive(1'b0, 1'b0, WEN_ALL, 12'h010, PAT_5A);
    checks++;
    if (OOR !== 1'b0) begin failures++; $display("FAIL wr_oor got=%b exp=0", OOR); end
    drive(1'b0, 1'b1, WEN_NONE, 12'h010, '0);
    checks++;
    if (Q !== PAT_5A) begin failures++; $display("FAIL wr_rd_q got=%h exp=%h", Q, PAT_5A); end
  endtask

  task automatic test_partial_mask();
    logic [DW-1:0] exp_q;
    exp_q = {{(DW-8){1'b1}}, 8'h00};
    drive(1'b0, 1'b0, WEN_ALL, 12'h020, ONES);
    drive(1'b0, 1'b0, {{(SEGS-1){1'b1}}, 1'b0}, 12'h020, '0);
    drive(1'b0, 1'b1, WEN_NONE, 12'h020, '0);
    checks++;
    if (Q !== exp_q) begin failures++; $display("FAIL partial_mask got=%h exp=%h", Q, exp_q); end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, WEN_NONE, 12'h010, '0);
    checks++;
    if (Q !== PAT_5A) begin failures++; $display("FAIL hold_read got=%h exp=%h", Q, PAT_5A); end
    for (int i = 0; i < 5; i++) begin
      idle();
      checks++;
      if (Q !== PAT_5A) begin failures++; $display("FAIL hold_idle%0d got=%h exp=%h", i, Q, PAT_5A); end
    end
    drive(1'b0, 1'b0, WEN_ALL, 12'h011, PAT_C3);
    checks++;
    if (Q !== PAT_5A) begin failures++; $display("FAIL hold_write got=%h exp=%h", Q, PAT_5A); end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, WEN_ALL, 12'h100, PAT_A1);
    drive(1'b0, 1'b0, WEN_ALL, 12'h101, PAT_B2);
    drive(1'b0, 1'b1, WEN_NONE, 12'h100, '0);
    checks++;
    if (Q !== PAT_A1) begin failures++; $display("FAIL b2b_rd0 got=%h exp=%h", Q, PAT_A1); end
    drive(1'b0, 1'b1, WEN_NONE, 12'h101, '0);
    checks++;
    if (Q !== PAT_B2) begin failures++; $display("FAIL b2b_rd1 got=%h exp=%h", Q, PAT_B2); end
    drive(1'b0, 1'b1, WEN_NONE, 12'h011, '0);
    checks++;
    if (Q !== PAT_C3) begin failures++; $display("FAIL b2b_rd2 got=%h exp=%h", Q, PAT_C3); end
    drive(1'b0, 1'b0, WEN_NONE, 12'h100, '0);
    checks++;
    if (Q !== PAT_C3 || OOR !== 1'b0) begin
      failures++; $display("FAIL noop_write_hold got=%h oor=%b exp=%h oor=0", Q, OOR, PAT_C3);
    end
    drive(1'b0, 1'b1, WEN_NONE, 12'h100, '0);
    checks++;
    if (Q !== PAT_A1) begin failures++; $display("FAIL noop_write_mem got=%h exp=%h", Q, PAT_A1); end
  endtask

  task automatic test_range();
    drive(1'b0, 1'b0, WEN_ALL, AW'(DEPTH - 1), PAT_C3);
    drive(1'b0, 1'b1, WEN_NONE, 12'h101, '0);
    drive(1'b0, 1'b0, WEN_ALL, AW'(DEPTH), ONES);
    checks++;
    if (OOR !== 1'b1) begin failures++; $display("FAIL oor_write_pulse got=%b exp=1", OOR); end
    checks++;
    if (Q !== PAT_B2) begin failures++; $display("FAIL oor_write_hold got=%h exp=%h", Q, PAT_B2); end
    drive(1'b0, 1'b1, WEN_NONE, AW'(DEPTH), '0);
    checks++;
    if (Q !== '0) begin failures++; $display("FAIL oor_read_q got=%h exp=0", Q); end
    checks++;
    if (OOR !== 1'b1) begin failures++; $display("FAIL oor_read_pulse got=%b exp=1", OOR); end
    drive(1'b0, 1'b1, WEN_NONE, AW'(DEPTH - 1), '0);
    checks++;
    if (Q !== PAT_C3) begin failures++; $display("FAIL last_addr_q got=%h exp=%h", Q, PAT_C3); end
    checks++;
    if (OOR !== 1'b0) begin failures++; $display("FAIL last_addr_oor got=%b exp=0", OOR); end
    idle();
    checks++;
    if (OOR !== 1'b0) begin failures++; $display("FAIL oor_idle got=%b exp=0", OOR); end
  endtask

  initial begin
    test_reset();
`ifdef CT_F_SPSRAM_INIT_EN
    test_init_sweep();
    test_reset_mid_sweep();
`endif
    test_write_read();
    test_partial_mask();
    test_hold();
    test_back_to_back();
    test_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ct_f_spsram_gen.md
# ct_f_spsram_gen

Parametrised single-port SRAM model for FPGA builds of the C910 memory hierarchy. It is the next-generation replacement for the fixed-geometry `ct_f_spsram_*` wrappers and covers any depth (including non-power-of-two), any width and a configurable write-mask granularity. It adds a registered, held read port, out-of-range access detection and an optional post-reset clearing sweep. It sits wherever a cache data/tag array instantiates a single-port macro.

## Interface
- `ADDR_WIDTH`, 12, address bits.
- `DEPTH`, 4096, number of entries; must satisfy `DEPTH <= 2**ADDR_WIDTH`.
- `DATA_WIDTH`, 144, data bits per entry.
- `MASK_GRAN`, 1, data bits controlled by one `WEN` bit; `DATA_WIDTH % MASK_GRAN == 0`.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `A`  in  ADDR_WIDTH  access address.
- `CEN`  in  1  chip enable, active low.
- `GWEN`  in  1  global write enable, active low; 1 = read.
- `WEN`  in  DATA_WIDTH/MASK_GRAN  per-segment write enable, active low.
- `D`  in  DATA_WIDTH  write data.
- `Q`  out  DATA_WIDTH  read data, registered and held.
- `BUSY`  out  1  high while the clearing sweep runs; accesses are ignored.
- `OOR`  out  1  one-cycle pulse: the previous accepted access had `A >= DEPTH`.

## Operation
- Accepted access: `CEN==0 && BUSY==0`.
- Read (`GWEN==1`): `Q` is loaded with `mem[A]` at the next edge.
- Write (`GWEN==0`): for each segment `s` with `WEN[s]==0`, `mem[A][s*MASK_GRAN +: MASK_GRAN] <= D[...]`. Other segments are untouched. `Q` holds its value (no read-during-write data).
- `GWEN==0` with all `WEN` high: no-op write. `Q` holds and `OOR` is still evaluated.
- No access (`CEN==1`): `Q` holds its last read value indefinitely.
- Out of range (`A >= DEPTH`): a write is dropped, a read loads `Q` with 0, and `OOR` pulses the following cycle.
- State machine (`INIT` exists only with the config macro):
  - `RST` → `INIT` if enabled, else `READY`.
  - `INIT`: counter `clr_addr` runs 0..DEPTH-1 and writes all-zero data. At `clr_addr==DEPTH-1` the next state is `READY`.
  - `READY` is terminal until `RST`.
- Reset mid-`INIT`: the sweep restarts at address 0. Memory contents are never reset directly.
- Reset values: `Q`=0, `OOR`=0, `BUSY`=1 if `INIT` is enabled else 0, `clr_addr`=0.

## Timing
- Read latency 1 cycle: address at edge N, data on `Q` after edge N+1.
- Back-to-back reads to any addresses are sustained at 1 per cycle.
- Write followed by a read of the same address in the next cycle returns the new data.
- `BUSY` falls on the edge that completes the write to `DEPTH-1`. The sweep takes exactly `DEPTH` cycles after `RST` deasserts, and the first access is accepted in the cycle `BUSY==0`.
- `OOR` is asserted exactly one cycle after the offending access edge, aligned with `Q`.

## Configuration
- `CT_F_SPSRAM_INIT_EN` defined:
  - The `INIT` state and `clr_addr` counter are compiled in.
  - Memory reads 0 everywhere after the sweep.
  - `BUSY` behaves as described above.
- Not defined:
  - No counter is built and `BUSY` is tied to 0.
  - Memory content after power-up is undefined (X in simulation, BRAM init value on the FPGA).
  - Accesses are accepted from the first cycle after `RST`.

## Structure
- Package `ct_f_spsram_pkg` holds:
  - the state enum (`INIT`, `READY`);
  - the `SEG_NUM = DATA_WIDTH/MASK_GRAN` derivation helper;
  - an elaboration check function for the `DEPTH`/`MASK_GRAN` legality rules.
- Sub-module `ct_f_spsram_seg` is one behavioural BRAM column of width `MASK_GRAN` and depth `DEPTH`, with a single enable. It is instantiated `SEG_NUM` times in a generate loop.
- The top level owns the FSM, the sweep mux on address/data/enable, the range compare and the output registers.

## Test plan
- Write/read with `DATA_WIDTH=144`, `MASK_GRAN=8`:
  - stimulus: write `D=0x5A…5A` to `A=0x010` with all `WEN=0`, then read `0x010`;
  - response: `Q=0x5A…5A` one cycle after the read.
- Partial mask:
  - stimulus: prefill `0x020` with all-ones, then write `D=0` with only `WEN[0]=0`, then read;
  - response: `Q[7:0]=0x00`, `Q[143:8]` all ones.
- Hold:
  - stimulus: read `0x010`, then hold `CEN=1` for 5 cycles, then do a write to `0x011`;
  - response: `Q` is unchanged throughout.
- Range, with `DEPTH=3000`:
  - stimulus: write to `A=3000`, then read `A=3000`, then read `A=2999`;
  - response: the write is dropped, the read returns `Q=0` with `OOR=1` for one cycle, and `A=2999` reads normally with `OOR=0`.
- Init sweep (macro defined, `DEPTH=16`):
  - stimulus: release `RST` and hold `CEN=0` for reads from cycle 0;
  - response: `BUSY=1` for 16 cycles with reads ignored, then `BUSY=0` and every address reads 0.
- Reset mid-sweep:
  - stimulus: assert `RST` at `clr_addr=7`;
  - response: after release, the sweep restarts at 0 and `BUSY` is high a full 16 cycles.
